// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walked LSB-first over WIDTH bits.
// Optional subtract mode (sub port, inverted B, carry seed 1) under SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             b_bit, seed;
    logic             ha1_s, ha1_c, ha2_s, ha2_c, c_next;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q, sub_d;
    assign b_bit = b_q[0] ^ sub_q;
    assign seed  = sub;
`else
    assign b_bit = b_q[0];
    assign seed  = 1'b0;
`endif

    // Full adder built from two half-adder stages plus the carry OR.
    assign ha1_s    = a_q[0] ^ b_bit;
    assign ha1_c    = a_q[0] & b_bit;
    assign ha2_s    = ha1_s ^ c_q;
    assign ha2_c    = ha1_s & c_q;
    assign c_next   = ha1_c | ha2_c;
    assign res_next = {ha2_s, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    c_d     = seed;
`ifdef SERIAL_ADD_SUB_EN
                    sub_d   = sub;
`endif
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = res_next[WIDTH-1:1];
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = res_next;
                    cout_d  = c_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: cycle-count acceptance model plus
// arithmetic reference; monitor pops expected results on done.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out;
    logic [W-1:0] sum;
    logic         sub_eff;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry_out(carry_out)
    );

`ifdef SERIAL_ADD_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    int         compared = 0;
    int         mismatched = 0;
    logic [W:0] exp_q[$];
    int         rem = 0;
    bit         done_m = 1'b0;
    logic [W:0] held = '0;

    function automatic logic [W:0] ref_res(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic s);
        logic [W-1:0] d;
        if (s) begin
            d = x - y;
            return {(x >= y), d};
        end
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model: W busy cycles after an accept, then one done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem = 0;
            done_m = 1'b0;
            exp_q.delete();
        end else if (rem > 0) begin
            rem--;
            done_m = (rem == 0);
        end else begin
            done_m = 1'b0;
            if (start) begin
                exp_q.push_back(ref_res(a, b, sub_eff));
                rem = W;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held = '0;
            check("reset_outputs", {busy, done, carry_out, sum}, 0);
        end else begin
            check("busy", busy, (rem > 0));
            check("done", done, done_m);
            if (done) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL done_unexpected: got done=1 expected no result");
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check("result", {carry_out, sum}, held);
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s);
        @(posedge clk); #2;
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rem != 0 || done_m) && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        check("wait_idle_timeout", (rem != 0 || done_m), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        issue(8'h3C, 8'h5A, 1'b0); wait_idle();
        issue(8'hFF, 8'h01, 1'b0); wait_idle();
        issue(8'h00, 8'h00, 1'b0); wait_idle();

        // start during RUN must be ignored
        issue(8'h12, 8'h34, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_idle();

        // start held high: back-to-back accepts
        @(posedge clk); #2;
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        a = 8'h80; b = 8'h80;
        repeat (W + 1) @(posedge clk);
        #2 start = 1'b0;
        wait_idle();

        // reset mid-RUN
        issue(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_async", {busy, done, carry_out, sum}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        issue(8'hAA, 8'h55, 1'b0); wait_idle();

`ifdef SERIAL_ADD_SUB_EN
        issue(8'h10, 8'h01, 1'b1); wait_idle();
        issue(8'h01, 8'h02, 1'b1); wait_idle();
`endif

        repeat (400) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 2) == 0);
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single one-bit add cell over two WIDTH-bit operands, LSB first, one bit per clock. The cell is two half-adder stages plus a carry OR, giving a full-adder bit. The block sits between a requester issuing start/operand pulses and downstream logic consuming a registered sum. It trades latency (WIDTH cycles) for a one-bit datapath, and owns the operand shift registers, carry flop, bit counter and start/busy/done handshake.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- sub  input  1  subtract select; captured with the operands. Present only when SERIAL_ADD_SUB_EN is defined.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held from done until the next accepted start.
- carry_out  output  1  final carry; held the same as sum.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE -> RUN when start=1. On this edge:
  - capture a into the A shift register and b into the B shift register;
  - clear the bit counter;
  - load the carry flop with 0 (1 when subtracting).
- RUN, every edge:
  - bit = A[0] ^ B'[0] ^ c, where B' is B, or ~B when subtracting;
  - c <= (A[0]&B'[0]) | (c&(A[0]^B'[0])), i.e. via two half-adder stages;
  - shift A and B right by one;
  - shift bit into the result register from the MSB side;
  - increment the counter.
- RUN -> DONE on the edge where counter == WIDTH-1 (the WIDTH-th bit processed). On that edge, sum takes the full result and carry_out takes the final carry.
- DONE -> RUN if start=1, which is a back-to-back accept with the same capture as from IDLE. Otherwise DONE -> IDLE.
- start while in RUN is ignored: no capture, no queuing, no effect on the current operation.
- a, b and sub may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH.
  - carry_out is the unsigned carry out of bit WIDTH-1.
  - No signed overflow flag.

## Timing
- Reset (async assert, any state): state=IDLE; busy=0, done=0, sum=0, carry_out=0; counter, carry flop and shift registers cleared.
- Reset deassertion is synchronized externally. The first active edge after deassertion may accept start.
- Reset mid-RUN aborts the operation: no done pulse, and sum/carry_out return to 0.
- Latency: with start sampled at edge E0, busy=1 after E0 through E(WIDTH-1). done=1 and sum/carry_out are valid after E(WIDTH), for exactly one cycle of done.
- Throughput: one result per WIDTH+1 cycles. With start held high continuously, done pulses every WIDTH+1 cycles.
- busy and done are never high together.
- sum/carry_out update only on the RUN->DONE edge. They are stable at all other times, including during RUN.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - the sub port exists;
  - sub=1 inverts B per bit and seeds carry=1, computing a-b mod 2^WIDTH;
  - carry_out=1 means no borrow (a>=b unsigned).
- SERIAL_ADD_SUB_EN undefined:
  - no sub port and no inversion logic;
  - carry seed is always 0, so the block adds only.

## Test plan
- WIDTH=8, a=0x3C, b=0x5A, start for 1 cycle -> busy for 8 cycles; then done=1 with sum=0x96, carry_out=0; done low on the next cycle.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0x00, b=0x00 -> sum=0x00, carry_out=0.
- Start at 0x12+0x34; pulse start with a=0xFF, b=0xFF at the 3rd RUN cycle -> ignored; result is sum=0x46, carry_out=0, and no second done follows.
- start held high with 0x01+0x01, then 0x80+0x80 -> done after 9 cycles (sum=0x02, c=0), then 9 cycles later (sum=0x00, c=1). busy low only in the DONE cycle.
- Assert rst_n=0 at the 4th RUN cycle of 0xAA+0x55, release 2 cycles later -> outputs 0 immediately; no done; a fresh 0xAA+0x55 yields sum=0xFF, c=0.
- With SERIAL_ADD_SUB_EN: sub=1, 0x10-0x01 -> sum=0x0F, carry_out=1. 0x01-0x02 -> sum=0xFF, carry_out=0.
